serial_tx_ctrl: RTL

SERIAL_TX_CTRL -- requirements
Module: serial_tx_ctrl

---
 rtl/serial_tx_ctrl_pkg.sv | 20 ++
 rtl/serial_tx_ctrl_if.sv | 38 +++
 rtl/serial_tx_ctrl_tx_shift_reg.sv | 37 +++
 rtl/serial_tx_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/serial_tx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_tx_ctrl_pkg
// Purpose : Shared definitions for the serial transmit controller: FSM state
//           encoding and the default frame width. The RTL and the bench both
//           import this package, so they always agree on the encodings.
// Contents: state_t        -- IDLE=00, SHIFT=01, PARITY=10, FIN=11
//           DEFAULT_WIDTH  -- default number of data bits per frame
// ---------------------------------------------------------------------------
package serial_tx_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10,
    ST_FIN    = 2'b11
  } state_t;

endpackage

// File: rtl/serial_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// serial_tx_ctrl_if
// Purpose : Bundles the frame request, parallel data and serial status
//           signals of serial_tx_ctrl.
// Signals : START     frame request (sampled only while the controller idles)
//           DIN       parallel data, captured on the edge accepting START
//           SOUT      serial data, LSB first, idle level 1
//           BUSY      high during SHIFT and PARITY
//           DONE      one-cycle completion pulse (FIN)
//           dbg_state registered FSM state, for observation only
// Handshake: a frame starts on the falling clock edge at which the controller
//           is in IDLE and START=1; START is a level request, not a pulse, and
//           is ignored in every other state. There is no back-pressure.
// Modports: master drives START/DIN, slave (the controller) drives the rest.
// ---------------------------------------------------------------------------
interface serial_tx_ctrl_if #(
  parameter int WIDTH = 8
) ();
  import serial_tx_ctrl_pkg::*;

  logic             START;
  logic [WIDTH-1:0] DIN;
  logic             SOUT;
  logic             BUSY;
  logic             DONE;
  state_t           dbg_state;

  modport master (
    output START, DIN,
    input  SOUT, BUSY, DONE, dbg_state
  );

  modport slave (
    input  START, DIN,
    output SOUT, BUSY, DONE, dbg_state
  );

endinterface

// File: rtl/serial_tx_ctrl_tx_shift_reg.sv
// ---------------------------------------------------------------------------
// tx_shift_reg
// Purpose : WIDTH-bit right-shifting data register built from falling-edge
//           D flip-flops with synchronous clear. Bit 0 is the serial output.
// Ports   : clk       clock (state changes on the falling edge)
//           clr       synchronous clear, highest priority
//           load      parallel load of din
//           shift_en  shift right by one, zero fill at the MSB
//           din       parallel data
//           sout      current bit 0
// ---------------------------------------------------------------------------
module tx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] r_data;

  always_ff @(negedge clk) begin
    if (clr) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= din;
    end else if (shift_en) begin
      r_data <= {1'b0, r_data[WIDTH-1:1]};
    end
  end

  assign sout = r_data[0];

endmodule

// File: rtl/serial_tx_ctrl.sv
// ---------------------------------------------------------------------------
// serial_tx_ctrl
// Purpose : Serialises a WIDTH-bit word LSB first. Frame = WIDTH data cycles,
//           an optional even-parity cycle, then one FIN cycle with DONE=1.
//           All state changes on the falling edge of C; all outputs are
//           decoded from registered state only.
// Ports   : C    clock (falling edge active)
//           RST  synchronous active-high reset, sampled on the falling edge
//           bus  serial_tx_ctrl_if.slave (START, DIN, SOUT, BUSY, DONE,
//                dbg_state)
// Config  : SERIAL_TX_PARITY_EN defined   -> PARITY cycle after the data bits
//           SERIAL_TX_PARITY_EN undefined -> no parity cycle, no accumulator
// ---------------------------------------------------------------------------
module serial_tx_ctrl
  import serial_tx_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              C,
  input  logic              RST,
  serial_tx_ctrl_if.slave   bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_load;
  logic            w_shift;
  logic            w_bit0;

  tx_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (C),
    .clr      (RST),
    .load     (w_load),
    .shift_en (w_shift),
    .din      (bus.DIN),
    .sout     (w_bit0)
  );

  // Next-state and datapath strobes
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.START) begin
          w_next = ST_SHIFT;
          w_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == LAST) begin
`ifdef SERIAL_TX_PARITY_EN
          w_next = ST_PARITY;
`else
          w_next = ST_FIN;
`endif
        end
      end
      ST_PARITY: w_next = ST_FIN;
      ST_FIN:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(negedge C) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Bit counter parks at WIDTH-1 on the last shift so it never wraps;
  // it is cleared again when the next frame is accepted.
  always_ff @(negedge C) begin
    if (RST || w_load) begin
      r_cnt <= '0;
    end else if (w_shift && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Even parity: XOR of every bit as it leaves the shift register.
  logic r_par;

  always_ff @(negedge C) begin
    if (RST || w_load) begin
      r_par <= 1'b0;
    end else if (w_shift) begin
      r_par <= r_par ^ w_bit0;
    end
  end
`endif

  // Moore output decode
  always_comb begin
    bus.SOUT = 1'b1;
    bus.BUSY = 1'b0;
    bus.DONE = 1'b0;
    case (r_state)
      ST_SHIFT: begin
        bus.SOUT = w_bit0;
        bus.BUSY = 1'b1;
      end
      ST_PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
        bus.SOUT = r_par;
`endif
        bus.BUSY = 1'b1;
      end
      ST_FIN:  bus.DONE = 1'b1;
      default: ;
    endcase
  end

  assign bus.dbg_state = r_state;

endmodule
